t03_decode_stage: RTL and testbench
===================================

T03_DECODE_STAGE -- requirements
Module: t03_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width of pc and imm; legal values 32 and 64.
REQ-002 The block SHALL have parameter RV64W, default 0, meaning 1 = OP-IMM-32 (0011011) and OP-32 (0111011) are decoded, 0 = both are illegal.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  nRst  in  1  asynchronous, active-low reset
  flush  in  1  discard held and incoming instruction
  in_valid  in  1  inst/pc valid
  in_ready  out  1  stage can accept
  inst  in  32  raw instruction
  pc  in  XLEN  instruction address
  out_valid  out  1  decoded bundle valid
  out_ready  in  1  consumer accepts bundle
  out_pc  out  XLEN  registered pc
  rs1, rs2, rd  out  5 each  register indices
  type_out  out  3  R=0 I=1 S=2 B=3 J=4 U=5 illegal=7
  control_out  out  17  {funct7, funct3, opcode}
  imm  out  XLEN  sign-extended immediate
  illegal  out  1  unsupported encoding
  dec_count  out  16  accepted-instruction counter

Function
REQ-004 The block SHALL be a single registered pipeline stage with a latency of 1 cycle from acceptance to out_valid.
REQ-005 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-006 An instruction SHALL be accepted when in_valid && in_ready; all output fields SHALL load on the next clock edge, and out_valid SHALL be set to 1.
REQ-007 When out_valid && out_ready and no acceptance occurs, out_valid SHALL clear to 0 on the next edge.
REQ-008 When out_valid && !out_ready, all outputs SHALL hold stable.
REQ-009 flush SHALL clear out_valid on the next edge; no instruction is accepted during a flush cycle. flush SHALL override any simultaneous handshake.
REQ-010 The opcode (inst[6:0]) SHALL map to type_out as follows:
  I: 0000011, 0010011, 1100111, 1110011
  R: 0110011
  S: 0100011
  B: 1100011
  J: 1101111
  U: 0110111, 0010111
  0011011 -> I and 0111011 -> R only when RV64W=1.
REQ-011 Any other opcode, or inst[1:0] != 2'b11, SHALL give type_out=7, illegal=1, and rs1=rs2=rd=0, funct7=funct3=0, imm=0; the opcode field of control_out still carries inst[6:0].
REQ-012 Field zeroing SHALL apply per type:
  R: all fields from inst.
  I: rs2=0; funct7=0, except OP-IMM/OP-IMM-32 with funct3 001 or 101, where funct7=inst[31:25].
  S/B: rd=0, funct7=0.
  J/U: rs1=rs2=0, funct3=0, funct7=0.
REQ-013 imm SHALL be sign-extended to XLEN from inst[31] as follows:
  I: inst[31:20]
  S: {inst[31:25], inst[11:7]}
  B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  U: {inst[31:12], 12'b0}
  R: 0
REQ-014 dec_count SHALL increment by 1 on each acceptance, including illegal instructions.
REQ-015 dec_count SHALL wrap from 16'hFFFF to 0, and SHALL NOT be affected by flush.

Reset
REQ-016 While nRst=0, all registered outputs SHALL be 0 asynchronously: out_valid, out_pc, rs1, rs2, rd, type_out, control_out, imm, illegal, dec_count.
REQ-017 in_ready SHALL be 1 during reset unless flush=1.
REQ-018 Reset asserted mid-transfer SHALL drop the held bundle; no output SHALL be presented after release until a new acceptance.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  a) inst=32'h00B50533 (add x10,x10,x11), accepted, out_ready=1 -> next cycle out_valid=1, type_out=0, rs1=10, rs2=11, rd=10, control_out={7'h00,3'h0,7'h33}, imm=0.
  b) inst=32'hFFF00093 (addi x1,x0,-1) with XLEN=64 -> type_out=1, imm=64'hFFFF_FFFF_FFFF_FFFF, rs2=0.
  c) inst=32'h4020D093 (srai x1,x1,2) -> funct7=7'h20 in control_out; same test with inst=32'h0000003B and RV64W=0 -> illegal=1, type_out=7.
  d) out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; when out_ready=1, the next instruction loads on the following edge with no bubble.
  e) flush in the same cycle as in_valid=1 -> no acceptance, out_valid=0 next cycle, dec_count unchanged.
  f) dec_count preset to 16'hFFFF via 65535 acceptances, then one more acceptance -> 0; nRst pulse mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/t03_decode_stage.sv
// ----------------------------------------------------------------------------
// t03_decode_stage
// Single registered decode stage for RV32I/RV64I base encodings.
// An accepted instruction is split into register indices, type class,
// {funct7, funct3, opcode} control bundle and a sign-extended immediate.
// The bundle appears one cycle after acceptance.
//
// Parameters
//   XLEN   width of pc / imm (32 or 64)
//   RV64W  1 = decode OP-IMM-32 / OP-32, 0 = treat them as illegal
//
// Ports
//   clk, nRst          clock (rising edge), asynchronous active-low reset
//   flush              discard the held bundle and any incoming instruction
//   in_valid/in_ready  upstream handshake for inst/pc
//   out_valid/out_ready downstream handshake for the decoded bundle
//   out_pc             pc of the held instruction
//   rs1, rs2, rd       register indices (zeroed when unused by the type)
//   type_out           R=0 I=1 S=2 B=3 J=4 U=5 illegal=7
//   control_out        {funct7, funct3, opcode}
//   imm                sign-extended immediate
//   illegal            unsupported encoding
//   dec_count          wrapping count of accepted instructions
// ----------------------------------------------------------------------------
module t03_decode_stage #(
  parameter int XLEN  = 32,
  parameter bit RV64W = 1'b0
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      type_out,
  output logic [16:0]     control_out,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [15:0]     dec_count
);

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_J   = 3'd4;
  localparam logic [2:0] T_U   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  function automatic logic [2:0] op_type(input logic [31:0] i);
    if (i[1:0] != 2'b11) return T_ILL;
    case (i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: return T_I;
      OPC_OP:       return T_R;
      OPC_STORE:    return T_S;
      OPC_BRANCH:   return T_B;
      OPC_JAL:      return T_J;
      OPC_LUI, OPC_AUIPC: return T_U;
      OPC_OP_IMM32: return RV64W ? T_I : T_ILL;
      OPC_OP32:     return RV64W ? T_R : T_ILL;
      default:      return T_ILL;
    endcase
  endfunction

  // Immediate is assembled as a signed 32-bit value, then the size cast
  // sign-extends it to XLEN.
  function automatic logic signed [XLEN-1:0] imm_ext(input logic [31:0] i,
                                                     input logic [2:0]  t);
    logic signed [31:0] v;
    case (t)
      T_I:     v = {{20{i[31]}}, i[31:20]};
      T_S:     v = {{20{i[31]}}, i[31:25], i[11:7]};
      T_B:     v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_J:     v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      T_U:     v = {i[31:12], 12'b0};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  logic                   accept;
  logic [2:0]             typ_p0;
  logic [4:0]             rs1_p0, rs2_p0, rd_p0;
  logic [2:0]             f3_p0;
  logic [6:0]             f7_p0;
  logic signed [XLEN-1:0] imm_p0;

  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [4:0]             rs1_p1, rs2_p1, rd_p1;
  logic [2:0]             typ_p1;
  logic [16:0]            ctrl_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic                   ill_p1;
  logic [15:0]            cnt_p1;

  assign in_ready = (!vld_p1 || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // ---- stage p0: combinational field extraction and per-type zeroing ----
  always_comb begin
    typ_p0 = op_type(inst);
    rs1_p0 = inst[19:15];
    rs2_p0 = inst[24:20];
    rd_p0  = inst[11:7];
    f3_p0  = inst[14:12];
    f7_p0  = inst[31:25];
    case (typ_p0)
      T_R: ;
      T_I: begin
        rs2_p0 = '0;
        // Shift-immediates keep funct7 (it selects srli/srai).
        if (!((inst[6:0] == OPC_OP_IMM || inst[6:0] == OPC_OP_IMM32) &&
              inst[13:12] == 2'b01))
          f7_p0 = '0;
      end
      T_S, T_B: begin
        rd_p0 = '0;
        f7_p0 = '0;
      end
      T_J, T_U: begin
        rs1_p0 = '0;
        rs2_p0 = '0;
        f3_p0  = '0;
        f7_p0  = '0;
      end
      default: begin
        rs1_p0 = '0;
        rs2_p0 = '0;
        rd_p0  = '0;
        f3_p0  = '0;
        f7_p0  = '0;
      end
    endcase
    imm_p0 = imm_ext(inst, typ_p0);
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
      typ_p1  <= '0;
      ctrl_p1 <= '0;
      imm_p1  <= '0;
      ill_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept)    vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;

      if (accept) begin
        pc_p1   <= pc;
        rs1_p1  <= rs1_p0;
        rs2_p1  <= rs2_p0;
        rd_p1   <= rd_p0;
        typ_p1  <= typ_p0;
        ctrl_p1 <= {f7_p0, f3_p0, inst[6:0]};
        imm_p1  <= imm_p0;
        ill_p1  <= (typ_p0 == T_ILL);
        cnt_p1  <= cnt_p1 + 16'd1;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign rs1         = rs1_p1;
  assign rs2         = rs2_p1;
  assign rd          = rd_p1;
  assign type_out    = typ_p1;
  assign control_out = ctrl_p1;
  assign imm         = imm_p1;
  assign illegal     = ill_p1;
  assign dec_count   = cnt_p1;

endmodule

// File: tb/tb_t03_decode_stage.sv
module tb_t03_decode_stage;
  localparam int XLEN  = 64;
  localparam bit RV64W = 1'b0;

  logic            clk = 1'b0;
  logic            nRst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, illegal;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc, out_pc, imm;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      type_out;
  logic [16:0]     control_out;
  logic [15:0]     dec_count;

  t03_decode_stage #(.XLEN(XLEN), .RV64W(RV64W)) dut (
    .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .inst(inst), .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .type_out(type_out), .control_out(control_out), .imm(imm),
    .illegal(illegal), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  typ;
    logic [16:0] ctrl;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endfunction

  // Reference decode: instruction class from the opcode table, immediates
  // computed as integer values (weighted bit sums minus the sign weight).
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p);
    exp_t   e;
    int     k;
    longint v;
    logic [6:0] opc = i[6:0];
    logic [2:0] f3  = i[14:12];
    logic [6:0] f7  = i[31:25];
    if (i[1:0] != 2'b11) k = 7;
    else case (opc)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: k = 1;
      7'b0110011: k = 0;
      7'b0100011: k = 2;
      7'b1100011: k = 3;
      7'b1101111: k = 4;
      7'b0110111, 7'b0010111: k = 5;
      7'b0011011: k = RV64W ? 1 : 7;
      7'b0111011: k = RV64W ? 0 : 7;
      default:    k = 7;
    endcase
    e.pc  = p;
    e.typ = 3'(k);
    e.ill = (k == 7);
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    v = 0;
    case (k)
      0: ;
      1: begin
        e.rs2 = 0;
        if (!((opc == 7'b0010011 || opc == 7'b0011011) && (f3 == 3'd1 || f3 == 3'd5))) f7 = 0;
        v = longint'(i[31:20]);
        if (i[31]) v -= 4096;
      end
      2: begin
        e.rd = 0; f7 = 0;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v -= 4096;
      end
      3: begin
        e.rd = 0; f7 = 0;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v -= 8192;
      end
      4, 5: begin
        e.rs1 = 0; e.rs2 = 0; f3 = 0; f7 = 0;
        if (k == 4) begin
          v = longint'(i[31]) * (64'd1 << 20) + longint'(i[19:12]) * 4096 +
              longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
          if (i[31]) v -= (64'd1 << 21);
        end else begin
          v = longint'(i[31:12]) * 4096;
          if (i[31]) v -= (64'd1 << 32);
        end
      end
      default: begin
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; f3 = 0; f7 = 0;
      end
    endcase
    e.ctrl = {f7, f3, opc};
    e.imm  = 64'(v);
    return e;
  endfunction

  // Monitor / scoreboard: queue non-empty means a bundle is expected on the
  // outputs this cycle.
  always @(negedge clk) begin
    if (nRst) begin
      chk("in_ready", 64'(in_ready), 64'(((q.size() == 0) || out_ready) && !flush));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("dec_count", 64'(dec_count), 64'(exp_cnt));
      if (q.size() != 0) begin
        if (out_valid) begin
          chk("out_pc", out_pc, q[0].pc);
          chk("rs1", 64'(rs1), 64'(q[0].rs1));
          chk("rs2", 64'(rs2), 64'(q[0].rs2));
          chk("rd", 64'(rd), 64'(q[0].rd));
          chk("type_out", 64'(type_out), 64'(q[0].typ));
          chk("control_out", 64'(control_out), 64'(q[0].ctrl));
          chk("imm", imm, q[0].imm);
          chk("illegal", 64'(illegal), 64'(q[0].ill));
        end
        if (flush || out_ready) void'(q.pop_front());
      end
    end
  end

  // One clock: decide acceptance from the model, then push after the edge.
  task automatic cycle();
    logic acc;
    exp_t e;
    acc = in_valid && nRst && ((q.size() == 0) || out_ready) && !flush;
    e   = model(inst, pc);
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back(e);
      exp_cnt++;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [14] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                              7'b0110011, 7'b0100011, 7'b1100011, 7'b1101111,
                              7'b0110111, 7'b0010111, 7'b0011011, 7'b0111011,
                              7'b0001111, 7'b1010011};
    logic [31:0] r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], opcs[$urandom_range(0, 13)]};
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] cnt_save;

  initial begin
    nRst = 0; flush = 0; in_valid = 0; out_ready = 1; inst = 0; pc = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dec_count", 64'(dec_count), 64'd0);
    chk("rst_ctrl", 64'(control_out), 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    flush = 1;
    #1;
    chk("rst_in_ready_flush", 64'(in_ready), 64'd0);
    flush = 0;
    repeat (2) @(posedge clk);
    #1 nRst = 1;

    // a) add x10,x10,x11
    in_valid = 1; inst = 32'h00B50533; pc = 64'h1000;
    cycle();
    in_valid = 0;
    chk("a_valid", 64'(out_valid), 64'd1);
    chk("a_type", 64'(type_out), 64'd0);
    chk("a_rs1", 64'(rs1), 64'd10);
    chk("a_rs2", 64'(rs2), 64'd11);
    chk("a_rd", 64'(rd), 64'd10);
    chk("a_ctrl", 64'(control_out), 64'({7'h00, 3'h0, 7'h33}));
    chk("a_imm", imm, 64'd0);

    // b) addi x1,x0,-1
    in_valid = 1; inst = 32'hFFF00093; pc = 64'h1004;
    cycle();
    in_valid = 0;
    chk("b_type", 64'(type_out), 64'd1);
    chk("b_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_rs2", 64'(rs2), 64'd0);

    // c) srai x1,x1,2 then OP-32 with RV64W=0
    in_valid = 1; inst = 32'h4020D093; pc = 64'h1008;
    cycle();
    chk("c_funct7", 64'(control_out[16:10]), 64'h20);
    chk("c_imm", imm, 64'h402);
    inst = 32'h0000003B; pc = 64'h100C;
    cycle();
    chk("c_illegal", 64'(illegal), 64'd1);
    chk("c_type", 64'(type_out), 64'd7);
    chk("c_ctrl", 64'(control_out), 64'h3B);

    // d) stall with in_valid held high, then release with no bubble
    inst = 32'h00A28293; pc = 64'h2000;
    cycle();
    out_ready = 0; inst = 32'h00C00313; pc = 64'h2004;
    repeat (3) begin
      cycle();
      chk("d_in_ready", 64'(in_ready), 64'd0);
      chk("d_hold_rd", 64'(rd), 64'd5);
      chk("d_hold_pc", out_pc, 64'h2000);
    end
    out_ready = 1;
    cycle();
    in_valid = 0;
    chk("d_next_valid", 64'(out_valid), 64'd1);
    chk("d_next_rd", 64'(rd), 64'd6);
    chk("d_next_imm", imm, 64'd12);
    cycle();

    // e) flush alongside in_valid drops held and incoming
    out_ready = 0; in_valid = 1; inst = 32'h00100093; pc = 64'h3000;
    cycle();
    cnt_save = exp_cnt;
    flush = 1; inst = 32'h00200113; pc = 64'h3004;
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("e_valid", 64'(out_valid), 64'd0);
    chk("e_count", 64'(dec_count), 64'(cnt_save));
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      inst      = rand_inst();
      pc        = {$urandom(), $urandom()};
      cycle();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    cycle();

    // f) counter wrap, then reset during a stall
    in_valid = 1;
    for (int n = 0; n < 70000 && exp_cnt != 16'hFFFF; n++) begin
      inst = rand_inst();
      pc   = {$urandom(), $urandom()};
      cycle();
    end
    chk("f_count_max", 64'(dec_count), 64'hFFFF);
    inst = 32'h00000013;
    cycle();
    chk("f_count_wrap", 64'(dec_count), 64'd0);
    out_ready = 0; inst = 32'hDEADB0B7;
    cycle();
    cycle();
    nRst = 0;
    #1;
    chk("f_rst_valid", 64'(out_valid), 64'd0);
    chk("f_rst_pc", out_pc, 64'd0);
    chk("f_rst_rs1", 64'(rs1), 64'd0);
    chk("f_rst_rs2", 64'(rs2), 64'd0);
    chk("f_rst_rd", 64'(rd), 64'd0);
    chk("f_rst_type", 64'(type_out), 64'd0);
    chk("f_rst_ctrl", 64'(control_out), 64'd0);
    chk("f_rst_imm", imm, 64'd0);
    chk("f_rst_illegal", 64'(illegal), 64'd0);
    chk("f_rst_count", 64'(dec_count), 64'd0);
    q.delete();
    exp_cnt = 0;
    in_valid = 0;
    cycle();
    nRst = 1; out_ready = 1;
    repeat (3) cycle();
    chk("f_post_rst_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
